// File: rtl/acl_spi_sequencer.sv
// Frame sequencer for an SPI accelerometer: writes two config words, then
// polls the X/Y/Z data registers with slave-select guard timing and a reply timeout.
module acl_spi_sequencer #(
  parameter logic [23:0] STARTUP_CYCLES = 24'd100000,
  parameter logic [7:0]  SS_GUARD       = 8'd16,
  parameter logic [23:0] POLL_GAP       = 24'd10000,
  parameter logic [23:0] TIMEOUT        = 24'd200000,
  parameter logic [15:0] CFG0           = 16'h2D08,
  parameter logic [15:0] CFG1           = 16'h3100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        done_in,
  input  logic [7:0]  rxbuffer,
  output logic        transmit,
  output logic [15:0] txbuffer,
  output logic        ss,
  output logic [7:0]  x_data,
  output logic [7:0]  y_data,
  output logic [7:0]  z_data,
  output logic        data_valid,
  output logic        cfg_done,
  output logic        error
);

  localparam int unsigned CNT_W = 24;
  localparam int unsigned CMP_W = CNT_W + 1;

  localparam logic [2:0] S_STARTUP = 3'd0;
  localparam logic [2:0] S_PARK    = 3'd1;
  localparam logic [2:0] S_SETUP   = 3'd2;
  localparam logic [2:0] S_START   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;
  localparam logic [2:0] S_GAP     = 3'd6;

  localparam logic [2:0] STEP_CFG0 = 3'd0;
  localparam logic [2:0] STEP_CFG1 = 3'd1;
  localparam logic [2:0] STEP_X    = 3'd2;
  localparam logic [2:0] STEP_Y    = 3'd3;
  localparam logic [2:0] STEP_Z    = 3'd4;

  logic [2:0]       r_state, w_state_nxt;
  logic [2:0]       r_step, w_step_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_retry, w_retry_nxt;
  logic             r_done_d;
  logic             r_transmit, w_transmit_nxt;
  logic [15:0]      r_txbuffer, w_txbuffer_nxt;
  logic             r_ss, w_ss_nxt;
  logic [7:0]       r_x, w_x_nxt;
  logic [7:0]       r_y, w_y_nxt;
  logic [7:0]       r_z, w_z_nxt;
  logic             r_dv, w_dv_nxt;
  logic             r_cfg_done, w_cfg_done_nxt;
  logic             r_error, w_error_nxt;
  logic             w_go_setup;

  logic [CMP_W-1:0] w_cnt_p1;
  logic             w_startup_end, w_guard_end, w_hold_end, w_gap_end, w_wait_expired;
  logic             w_done_rise;

  function automatic logic [15:0] frame_word(input logic [2:0] step);
    case (step)
      STEP_CFG0: frame_word = CFG0;
      STEP_CFG1: frame_word = CFG1;
      STEP_X:    frame_word = 16'hB200;
      STEP_Y:    frame_word = 16'hB400;
      STEP_Z:    frame_word = 16'hB600;
      default:   frame_word = 16'h0000;
    endcase
  endfunction

  // Terminal-count compares in one extra bit so limits near 2^24 cannot wrap.
  assign w_cnt_p1       = CMP_W'(r_cnt) + CMP_W'(1);
  assign w_cnt_inc      = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_startup_end  = w_cnt_p1 >= CMP_W'(STARTUP_CYCLES);
  assign w_guard_end    = w_cnt_p1 >= CMP_W'(SS_GUARD);
  assign w_hold_end     = w_cnt_p1 >= CMP_W'({SS_GUARD, 1'b0});
  assign w_gap_end      = w_cnt_p1 >= CMP_W'(POLL_GAP);
  // The START cycle counts toward the transmit-to-done_in budget.
  assign w_wait_expired = (w_cnt_p1 + CMP_W'(1)) >= CMP_W'(TIMEOUT);
  assign w_done_rise    = done_in & ~r_done_d;

  always_comb begin
    w_state_nxt    = r_state;
    w_step_nxt     = r_step;
    w_cnt_nxt      = w_cnt_inc;
    w_retry_nxt    = r_retry;
    w_transmit_nxt = 1'b0;
    w_txbuffer_nxt = r_txbuffer;
    w_ss_nxt       = r_ss;
    w_x_nxt        = r_x;
    w_y_nxt        = r_y;
    w_z_nxt        = r_z;
    w_dv_nxt       = 1'b0;
    w_cfg_done_nxt = r_cfg_done;
    w_error_nxt    = r_error;
    w_go_setup     = 1'b0;

    case (r_state)
      S_STARTUP: begin
        w_ss_nxt = 1'b1;
        if (w_startup_end) begin
          w_go_setup = 1'b1;
          w_step_nxt = STEP_CFG0;
        end
      end
      S_PARK: begin
        w_ss_nxt = 1'b1;
        if (enable) begin
          w_go_setup = 1'b1;
          w_step_nxt = STEP_X;
        end
      end
      S_SETUP: begin
        if (w_guard_end) begin
          w_state_nxt    = S_START;
          w_transmit_nxt = 1'b1;
        end
      end
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_done_rise) begin
          w_state_nxt = S_HOLD;
          w_retry_nxt = 1'b0;
          case (r_step)
            STEP_X: w_x_nxt = rxbuffer;
            STEP_Y: w_y_nxt = rxbuffer;
            STEP_Z: begin
              w_z_nxt  = rxbuffer;
              w_dv_nxt = 1'b1;
            end
            default: ;
          endcase
        end else if (w_wait_expired) begin
          w_state_nxt = S_HOLD;
          w_retry_nxt = 1'b1;
          w_error_nxt = 1'b1;
          w_ss_nxt    = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_guard_end) w_ss_nxt = 1'b1;
        if (w_hold_end) begin
          if (r_retry) begin
            w_go_setup = 1'b1;
          end else begin
            case (r_step)
              STEP_CFG0: begin
                w_step_nxt = STEP_CFG1;
                w_go_setup = 1'b1;
              end
              STEP_CFG1: begin
                w_cfg_done_nxt = 1'b1;
                w_step_nxt     = STEP_X;
                w_state_nxt    = S_PARK;
              end
              STEP_X, STEP_Y: begin
                if (enable) begin
                  w_step_nxt = r_step + 3'd1;
                  w_go_setup = 1'b1;
                end else begin
                  w_state_nxt = S_PARK;
                end
              end
              default: w_state_nxt = S_GAP;
            endcase
          end
        end
      end
      S_GAP: begin
        w_ss_nxt = 1'b1;
        if (w_gap_end) begin
          if (enable) begin
            w_go_setup = 1'b1;
            w_step_nxt = STEP_X;
          end else begin
            w_state_nxt = S_PARK;
          end
        end
      end
      default: w_state_nxt = S_STARTUP;
    endcase

    // Frame word is loaded once on SETUP entry and held until the frame retires.
    if (w_go_setup) begin
      w_state_nxt    = S_SETUP;
      w_ss_nxt       = 1'b0;
      w_retry_nxt    = 1'b0;
      w_txbuffer_nxt = frame_word(w_step_nxt);
    end
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_STARTUP;
      r_step     <= STEP_CFG0;
      r_cnt      <= '0;
      r_retry    <= 1'b0;
      r_done_d   <= 1'b0;
      r_transmit <= 1'b0;
      r_txbuffer <= 16'h0000;
      r_ss       <= 1'b1;
      r_x        <= 8'h00;
      r_y        <= 8'h00;
      r_z        <= 8'h00;
      r_dv       <= 1'b0;
      r_cfg_done <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_step     <= w_step_nxt;
      r_cnt      <= w_cnt_nxt;
      r_retry    <= w_retry_nxt;
      r_done_d   <= done_in;
      r_transmit <= w_transmit_nxt;
      r_txbuffer <= w_txbuffer_nxt;
      r_ss       <= w_ss_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_z        <= w_z_nxt;
      r_dv       <= w_dv_nxt;
      r_cfg_done <= w_cfg_done_nxt;
      r_error    <= w_error_nxt;
    end
  end

  assign transmit   = r_transmit;
  assign txbuffer   = r_txbuffer;
  assign ss         = r_ss;
  assign x_data     = r_x;
  assign y_data     = r_y;
  assign z_data     = r_z;
  assign data_valid = r_dv;
  assign cfg_done   = r_cfg_done;
  assign error      = r_error;

endmodule
